stdp_engine: RTL and testbench

- Multi-synapse STDP learning engine for one post-synaptic neuron with N_PRE pre-synaptic inputs.
- Holds the synaptic weight array, time-stamps spikes against a shared timestep counter, and queues LTP/LTD events per synapse.
- Serialises queued events through a round-robin sequencer that applies saturating weight updates and streams each update out over a valid/ready handshake.
- Sits between the spike-routing fabric and the neuron core, which reads the weights.

---
 rtl/stdp_pkg.sv | 35 +++
 rtl/stdp_rr_arbiter.sv | 29 ++
 rtl/stdp_engine.sv | 199 +++++++++++++++++++
 tb/tb_stdp_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared types and helpers for the STDP learning engine.
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_CALC = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

  localparam logic KIND_LTP = 1'b0;
  localparam logic KIND_LTD = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Unsigned add clamped to the largest w-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] max;
    max = (33'd1 << w) - 33'd1;
    s   = {1'b0, a} + {1'b0, b};
    return (s > max) ? max[31:0] : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (b > a) ? 32'd0 : a - b;
  endfunction

endpackage

// File: rtl/stdp_rr_arbiter.sv
// Round-robin pick of the lowest pending index at or after rr_ptr, wrapping.
module stdp_rr_arbiter
  import stdp_pkg::*;
#(
  parameter int unsigned N_PRE = 8,
  localparam int unsigned AW = clog2(N_PRE)
) (
  input  logic [N_PRE-1:0] pend,
  input  logic [AW-1:0]    rr_ptr,
  output logic [AW-1:0]    idx,
  output logic             found
);

  // Walk from the far end down so the nearest candidate is assigned last.
  always_comb begin
    logic [AW-1:0] j;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = N_PRE - 1; k >= 0; k--) begin
      j = rr_ptr + AW'(k);
      if (pend[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stdp_engine.sv
// STDP engine: spike time-stamping, per-synapse event slots, and a
// round-robin sequencer that applies saturating weight updates.
module stdp_engine
  import stdp_pkg::*;
#(
  parameter int unsigned N_PRE     = 8,
  parameter int unsigned WW        = 8,
  parameter int unsigned TW        = 8,
  parameter int unsigned TAU_SHIFT = 2,
  parameter int unsigned W_INIT    = 64,
  localparam int unsigned AW = clog2(N_PRE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick,
  input  logic [N_PRE-1:0] pre_spike,
  input  logic             post_spike,
  input  logic [WW-1:0]    ltp_rate,
  input  logic [WW-1:0]    ltd_rate,
  input  logic [TW-1:0]    time_window,
  input  logic [AW-1:0]    rd_addr,
  output logic [WW-1:0]    rd_data,
  input  logic             host_wr_en,
  input  logic [AW-1:0]    host_addr,
  input  logic [WW-1:0]    host_data,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [AW-1:0]    upd_addr,
  output logic [WW:0]      upd_delta,
  output logic             upd_ltd,
  output logic [31:0]      ltp_count,
  output logic [31:0]      ltd_count,
  output logic [31:0]      drop_count
);

  logic [TW-1:0]    now;
  logic [TW-1:0]    last_pre [N_PRE];
  logic [TW-1:0]    last_post;
  logic [N_PRE-1:0] pre_seen;
  logic             post_seen;
  logic [N_PRE-1:0] pend;
  logic [N_PRE-1:0] kind;
  logic [TW-1:0]    dtq [N_PRE];
  logic [WW-1:0]    weights [N_PRE];
  state_t           state;
  logic [AW-1:0]    rr_ptr;
  logic [AW-1:0]    cur_idx;
  logic             cur_kind;
  logic [TW-1:0]    cur_dt;
  logic [WW-1:0]    new_w;

  logic [AW-1:0]    arb_idx;
  logic             arb_found;

  stdp_rr_arbiter #(.N_PRE(N_PRE)) u_arb (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .idx    (arb_idx),
    .found  (arb_found)
  );

  assign rd_data = weights[rd_addr];

  // Event detection; pre and post in the same cycle is LTP at dt=0 only.
  logic [N_PRE-1:0] ev, ev_kind, drop_vec;
  logic [TW-1:0]    ev_dt [N_PRE];
  logic [TW-1:0]    dt_post, dt_pre;
  logic             scan_clr;
  logic [31:0]      drop_n;
  always_comb begin
    ev       = '0;
    ev_kind  = '0;
    drop_vec = '0;
    drop_n   = '0;
    dt_pre   = '0;
    dt_post  = now - last_post;
    scan_clr = (state == ST_SCAN) && arb_found;
    for (int i = 0; i < N_PRE; i++) begin
      ev_dt[i] = '0;
      dt_pre   = now - last_pre[i];
      if (enable && post_spike && (pre_spike[i] || (pre_seen[i] && dt_pre <= time_window))) begin
        ev[i]    = 1'b1;
        ev_dt[i] = pre_spike[i] ? '0 : dt_pre;
      end else if (enable && pre_spike[i] && post_seen && !post_spike && dt_post <= time_window) begin
        ev[i]      = 1'b1;
        ev_kind[i] = KIND_LTD;
        ev_dt[i]   = dt_post;
      end
      drop_vec[i] = ev[i] && pend[i] && !(scan_clr && arb_idx == AW'(i));
      drop_n      = drop_n + 32'(drop_vec[i]);
    end
  end

  // Exponential decay approximated by a right shift of the rate.
  logic [TW-1:0] shamt;
  logic [WW-1:0] rate, mag, w_cur, calc_w;
  logic [WW:0]   calc_delta;
  always_comb begin
    shamt      = cur_dt >> TAU_SHIFT;
    rate       = (cur_kind == KIND_LTD) ? ltd_rate : ltp_rate;
    mag        = (shamt >= TW'(WW)) ? '0 : rate >> shamt;
    w_cur      = weights[cur_idx];
    calc_w     = (cur_kind == KIND_LTD) ? WW'(sat_sub(32'(w_cur), 32'(mag)))
                                        : WW'(sat_add(32'(w_cur), 32'(mag), WW));
    calc_delta = {1'b0, calc_w} - {1'b0, w_cur};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now        <= '0;
      last_post  <= '0;
      post_seen  <= 1'b0;
      pre_seen   <= '0;
      pend       <= '0;
      kind       <= '0;
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      cur_idx    <= '0;
      cur_kind   <= KIND_LTP;
      cur_dt     <= '0;
      new_w      <= '0;
      upd_valid  <= 1'b0;
      upd_addr   <= '0;
      upd_delta  <= '0;
      upd_ltd    <= 1'b0;
      ltp_count  <= '0;
      ltd_count  <= '0;
      drop_count <= '0;
      for (int i = 0; i < N_PRE; i++) begin
        last_pre[i] <= '0;
        dtq[i]      <= '0;
        weights[i]  <= WW'(W_INIT);
      end
    end else begin
      if (tick) now <= now + TW'(1);
      if (enable) begin
        for (int i = 0; i < N_PRE; i++) begin
          if (pre_spike[i]) begin
            last_pre[i] <= now;
            pre_seen[i] <= 1'b1;
          end
        end
        if (post_spike) begin
          last_post <= now;
          post_seen <= 1'b1;
        end
      end

      // A fresh event takes the slot even in the cycle it is being issued.
      if (scan_clr) pend[arb_idx] <= 1'b0;
      for (int i = 0; i < N_PRE; i++) begin
        if (ev[i]) begin
          pend[i] <= 1'b1;
          kind[i] <= ev_kind[i];
          dtq[i]  <= ev_dt[i];
        end
      end
      drop_count <= drop_count + drop_n;

      case (state)
        ST_IDLE: if (|pend) state <= ST_SCAN;
        ST_SCAN: begin
          if (arb_found) begin
            cur_idx  <= arb_idx;
            cur_kind <= kind[arb_idx];
            cur_dt   <= dtq[arb_idx];
            state    <= ST_CALC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          new_w     <= calc_w;
          upd_addr  <= cur_idx;
          upd_delta <= calc_delta;
          upd_ltd   <= cur_kind;
          upd_valid <= 1'b1;
          state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (upd_ready) begin
            upd_valid        <= 1'b0;
            weights[cur_idx] <= new_w;
            if (cur_kind == KIND_LTD) ltd_count <= ltd_count + 32'd1;
            else                      ltp_count <= ltp_count + 32'd1;
            rr_ptr <= cur_idx + AW'(1);
            state  <= (|pend) ? ST_SCAN : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Host write is applied last so it overrides an engine commit.
      if (host_wr_en) weights[host_addr] <= host_data;
    end
  end

endmodule

// File: tb/tb_stdp_engine.sv
// Directed bench for stdp_engine with a queue of expected update records.
module tb_stdp_engine;

  localparam int AW = 3;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          tick = 1'b0;
  logic [7:0]    pre_spike = '0;
  logic          post_spike = 1'b0;
  logic [WW-1:0] ltp_rate = 8'd32;
  logic [WW-1:0] ltd_rate = 8'd100;
  logic [7:0]    time_window = 8'd20;
  logic [AW-1:0] rd_addr = '0;
  logic [WW-1:0] rd_data;
  logic          host_wr_en = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [WW-1:0] host_data = '0;
  logic          upd_valid;
  logic          upd_ready = 1'b0;
  logic [AW-1:0] upd_addr;
  logic [WW:0]   upd_delta;
  logic          upd_ltd;
  logic [31:0]   ltp_count, ltd_count, drop_count;

  stdp_engine dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .pre_spike(pre_spike),
    .post_spike(post_spike), .ltp_rate(ltp_rate), .ltd_rate(ltd_rate),
    .time_window(time_window), .rd_addr(rd_addr), .rd_data(rd_data),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_data(host_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
    .upd_delta(upd_delta), .upd_ltd(upd_ltd), .ltp_count(ltp_count),
    .ltd_count(ltd_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW:0]   delta;
    logic          ltd;
  } rec_t;

  rec_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic advance(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic spike(input logic [7:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    cyc();
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
    host_wr_en = 1'b1;
    host_addr  = a;
    host_data  = d;
    cyc();
    host_wr_en = 1'b0;
  endtask

  task automatic read_w(input string tag, input logic [AW-1:0] a, input logic [WW-1:0] exp);
    rd_addr = a;
    #1;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic expect_rec(input logic [AW-1:0] a, input logic [WW:0] d, input logic l);
    rec_t r;
    r.addr  = a;
    r.delta = d;
    r.ltd   = l;
    sb.push_back(r);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (upd_valid !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    chk("upd_valid_timeout", 64'(upd_valid), 64'd1);
  endtask

  // Pop each expected record and compare it; optionally stall, or host-write on the handshake.
  task automatic drain(input logic stall, input logic host_hs, input logic [WW-1:0] hdata);
    rec_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_valid();
      chk("upd_addr", 64'(upd_addr), 64'(e.addr));
      chk("upd_delta", 64'(upd_delta), 64'(e.delta));
      chk("upd_ltd", 64'(upd_ltd), 64'(e.ltd));
      if (stall) begin
        upd_ready = 1'b0;
        cyc();
        chk("stall_valid", 64'(upd_valid), 64'd1);
        chk("stall_addr", 64'(upd_addr), 64'(e.addr));
        chk("stall_delta", 64'(upd_delta), 64'(e.delta));
      end
      upd_ready = 1'b1;
      if (host_hs) begin
        host_wr_en = 1'b1;
        host_addr  = e.addr;
        host_data  = hdata;
      end
      cyc();
      upd_ready  = 1'b0;
      host_wr_en = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(upd_valid), 64'd0);
    chk("rst_ltp", 64'(ltp_count), 64'd0);
    chk("rst_ltd", 64'(ltd_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    for (int i = 0; i < 8; i++) read_w("rst_weight", AW'(i), 8'd64);

    // LTP: pre[3] at 10, post at 14 -> dt 4, shift 1, +16
    advance(10);
    spike(8'h08, 1'b0);
    advance(4);
    spike(8'h00, 1'b1);
    expect_rec(3'd3, 9'h010, 1'b0);
    drain(1'b0, 1'b0, 8'd0);
    read_w("ltp_weight", 3'd3, 8'd80);
    chk("ltp_count1", 64'(ltp_count), 64'd1);

    // LTD: post at 5, pre[1] at 6 -> 64-100 clamps to 0
    do_reset();
    advance(5);
    spike(8'h00, 1'b1);
    advance(1);
    spike(8'h02, 1'b0);
    expect_rec(3'd1, 9'h1C0, 1'b1);
    drain(1'b0, 1'b0, 8'd0);
    read_w("ltd_weight", 3'd1, 8'd0);
    chk("ltd_count1", 64'(ltd_count), 64'd1);
    chk("ltd_ltp_zero", 64'(ltp_count), 64'd0);

    // Upper saturation, then a zero-magnitude-effect update still counted
    do_reset();
    host_wr(3'd2, 8'd250);
    spike(8'h04, 1'b1);
    expect_rec(3'd2, 9'h005, 1'b0);
    drain(1'b0, 1'b0, 8'd0);
    read_w("sat_weight", 3'd2, 8'd255);
    spike(8'h04, 1'b1);
    expect_rec(3'd2, 9'h000, 1'b0);
    drain(1'b0, 1'b0, 8'd0);
    read_w("sat_weight2", 3'd2, 8'd255);
    chk("sat_ltp_count", 64'(ltp_count), 64'd2);

    // All eight channels, drained in index order with back-pressure
    do_reset();
    advance(2);
    spike(8'hFF, 1'b0);
    advance(1);
    spike(8'h00, 1'b1);
    for (int i = 0; i < 8; i++) expect_rec(AW'(i), 9'h020, 1'b0);
    drain(1'b1, 1'b0, 8'd0);
    read_w("rr_weight0", 3'd0, 8'd96);
    read_w("rr_weight7", 3'd7, 8'd96);
    chk("rr_ltp_count", 64'(ltp_count), 64'd8);

    // Disabled learning ignores spikes; outside window gives nothing
    do_reset();
    enable = 1'b0;
    spike(8'h01, 1'b1);
    repeat (10) cyc();
    chk("dis_valid", 64'(upd_valid), 64'd0);
    chk("dis_ltp", 64'(ltp_count), 64'd0);
    enable = 1'b1;
    spike(8'h04, 1'b0);
    advance(25);
    spike(8'h00, 1'b1);
    repeat (10) cyc();
    chk("win_valid", 64'(upd_valid), 64'd0);
    chk("win_ltp", 64'(ltp_count), 64'd0);
    read_w("win_weight", 3'd2, 8'd64);

    // Two LTD events on channel 5 before service -> one record, one drop
    do_reset();
    ltd_rate = 8'd10;
    spike(8'h00, 1'b1);
    advance(2);
    pre_spike = 8'h20;
    cyc();
    cyc();
    pre_spike = '0;
    expect_rec(3'd5, 9'h1F6, 1'b1);
    drain(1'b0, 1'b0, 8'd0);
    repeat (10) cyc();
    chk("drop_valid", 64'(upd_valid), 64'd0);
    chk("drop_count", 64'(drop_count), 64'd1);
    chk("drop_ltd", 64'(ltd_count), 64'd1);
    read_w("drop_weight", 3'd5, 8'd54);

    // Host write on the handshake cycle wins over the engine commit
    do_reset();
    spike(8'h10, 1'b1);
    expect_rec(3'd4, 9'h020, 1'b0);
    drain(1'b0, 1'b1, 8'd7);
    read_w("host_weight", 3'd4, 8'd7);
    chk("host_ltp", 64'(ltp_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
